// File: rtl/hazard5_wb_arbiter.sv
// Register-file writeback arbiter: merges in-order load responses with ALU results
// through a one-entry skid buffer and reports pending-write hazards for operand reads.
module hazard5_wb_arbiter #(
    parameter int W_DATA   = 32,
    parameter int W_ADDR   = 5,
    parameter int LD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [W_ADDR-1:0] alu_rd,
    input  logic [W_DATA-1:0] alu_wdata,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [W_ADDR-1:0] ld_issue_rd,
    output logic              ld_issue_ready,
    input  logic              ld_resp_valid,
    input  logic [W_DATA-1:0] ld_resp_data,
    input  logic              ld_resp_err,
    output logic [W_ADDR-1:0] waddr,
    output logic [W_DATA-1:0] wdata,
    output logic              wen,
    input  logic [W_ADDR-1:0] query_addr1,
    input  logic [W_ADDR-1:0] query_addr2,
    output logic              query_hazard1,
    output logic              query_hazard2,
    output logic              err_pulse
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W_ADDR-1:0] tag_mem_r [LD_DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              load_win_s;
    logic              alu_acc_s;
    logic              resp_err_s;
    logic [LD_DEPTH-1:0] tag_valid_s;

    logic              skid_valid_r;
    logic [W_ADDR-1:0] skid_rd_r;
    logic [W_DATA-1:0] skid_data_r;

    logic              sel_valid_s;
    logic [W_ADDR-1:0] sel_addr_s;
    logic [W_DATA-1:0] sel_data_s;
    logic              skid_load_s;
    logic              skid_drain_s;
    logic              write_s;
    logic              hit1_s;
    logic              hit2_s;

    assign full_s         = (count_r == CW'(LD_DEPTH));
    assign empty_s        = (count_r == {CW{1'b0}});
    assign ld_issue_ready = ~full_s;
    assign alu_ready      = ~skid_valid_r;
    assign push_s         = ld_issue & ~full_s;
    assign pop_s          = ld_resp_valid & ~empty_s;
    assign load_win_s     = pop_s & ~ld_resp_err;
    assign alu_acc_s      = alu_valid & ~skid_valid_r;
    // An error response and a response with no tag outstanding both raise err_pulse.
    assign resp_err_s     = ld_resp_valid & (empty_s | ld_resp_err);
    assign write_s        = sel_valid_s & (sel_addr_s != {W_ADDR{1'b0}});

    // Load tag FIFO: pointers wrap naturally because LD_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < LD_DEPTH; i++) begin
                tag_mem_r[i] <= {W_ADDR{1'b0}};
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= ld_issue_rd;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Writeback source priority: good load response, then skid entry, then ALU.
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_addr_s   = {W_ADDR{1'b0}};
        sel_data_s   = {W_DATA{1'b0}};
        skid_load_s  = 1'b0;
        skid_drain_s = 1'b0;
        if (load_win_s) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = tag_mem_r[rd_ptr_r];
            sel_data_s  = ld_resp_data;
            skid_load_s = alu_acc_s;
        end else if (skid_valid_r) begin
            sel_valid_s  = 1'b1;
            sel_addr_s   = skid_rd_r;
            sel_data_s   = skid_data_r;
            skid_drain_s = 1'b1;
        end else if (alu_acc_s) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = alu_rd;
            sel_data_s  = alu_wdata;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // ALU skid buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_r <= 1'b0;
            skid_rd_r    <= {W_ADDR{1'b0}};
            skid_data_r  <= {W_DATA{1'b0}};
        end else if (skid_load_s) begin
            skid_valid_r <= 1'b1;
            skid_rd_r    <= alu_rd;
            skid_data_r  <= alu_wdata;
        end else if (skid_drain_s) begin
            skid_valid_r <= 1'b0;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    // Registered register-file port; address/data hold while wen is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen       <= 1'b0;
            waddr     <= {W_ADDR{1'b0}};
            wdata     <= {W_DATA{1'b0}};
            err_pulse <= 1'b0;
        end else begin
            wen       <= write_s;
            err_pulse <= resp_err_s;
            if (write_s) begin
                waddr <= sel_addr_s;
                wdata <= sel_data_s;
            end else begin
                waddr <= waddr;
                wdata <= wdata;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        tag_valid_s = {LD_DEPTH{1'b0}};
        for (int i = 0; i < LD_DEPTH; i++) begin
            tag_valid_s[i] = ({1'b0, PW'(i) - rd_ptr_r} < count_r);
        end
    end

    // Hazard lookup across live tags, skid entry and the write in flight.
    always_comb begin
        hit1_s = (skid_valid_r & (skid_rd_r == query_addr1)) | (wen & (waddr == query_addr1));
        hit2_s = (skid_valid_r & (skid_rd_r == query_addr2)) | (wen & (waddr == query_addr2));
        for (int i = 0; i < LD_DEPTH; i++) begin
            hit1_s = hit1_s | (tag_valid_s[i] & (tag_mem_r[i] == query_addr1));
            hit2_s = hit2_s | (tag_valid_s[i] & (tag_mem_r[i] == query_addr2));
        end
        query_hazard1 = hit1_s & (query_addr1 != {W_ADDR{1'b0}});
        query_hazard2 = hit2_s & (query_addr2 != {W_ADDR{1'b0}});
    end

endmodule

// File: tb/tb_hazard5_wb_arbiter.sv
// Bench for hazard5_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model.
module tb_hazard5_wb_arbiter;

    localparam int W_DATA   = 32;
    localparam int W_ADDR   = 5;
    localparam int LD_DEPTH = 2;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic [W_ADDR-1:0] alu_rd;
    logic [W_DATA-1:0] alu_wdata;
    logic              alu_ready;
    logic              ld_issue;
    logic [W_ADDR-1:0] ld_issue_rd;
    logic              ld_issue_ready;
    logic              ld_resp_valid;
    logic [W_DATA-1:0] ld_resp_data;
    logic              ld_resp_err;
    logic [W_ADDR-1:0] waddr;
    logic [W_DATA-1:0] wdata;
    logic              wen;
    logic [W_ADDR-1:0] query_addr1;
    logic [W_ADDR-1:0] query_addr2;
    logic              query_hazard1;
    logic              query_hazard2;
    logic              err_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W_ADDR-1:0] mq[$];
    logic              m_sk_v;
    logic [W_ADDR-1:0] m_sk_rd;
    logic [W_DATA-1:0] m_sk_d;
    logic              m_wen;
    logic [W_ADDR-1:0] m_waddr;
    logic [W_DATA-1:0] m_wdata;
    logic              m_err;

    hazard5_wb_arbiter #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .LD_DEPTH(LD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_err(ld_resp_err),
        .waddr(waddr), .wdata(wdata), .wen(wen),
        .query_addr1(query_addr1), .query_addr2(query_addr2),
        .query_hazard1(query_hazard1), .query_hazard2(query_hazard2),
        .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hazard(input logic [W_ADDR-1:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        if (m_sk_v && m_sk_rd == a) return 1'b1;
        if (m_wen && m_waddr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sk_v = 1'b0; m_sk_rd = '0; m_sk_d = '0;
        m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    endtask

    task automatic check_all(input string w);
        chk({w, "_wen"}, wen, m_wen);
        chk({w, "_waddr"}, waddr, m_waddr);
        chk({w, "_wdata"}, wdata, m_wdata);
        chk({w, "_err"}, err_pulse, m_err);
        chk({w, "_alu_ready"}, alu_ready, !m_sk_v);
        chk({w, "_ld_ready"}, ld_issue_ready, mq.size() < LD_DEPTH);
        chk({w, "_haz1"}, query_hazard1, m_hazard(query_addr1));
        chk({w, "_haz2"}, query_hazard2, m_hazard(query_addr2));
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_wdata = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        ld_resp_valid = 1'b0; ld_resp_data = '0; ld_resp_err = 1'b0;
    endtask

    // Advance one clock: model consumes the inputs seen before the edge.
    task automatic cycle(input string w);
        bit empty, full, push, pop, acc, wr, nerr;
        logic [W_ADDR-1:0] wa;
        logic [W_DATA-1:0] wd;
        empty = (mq.size() == 0);
        full  = (mq.size() == LD_DEPTH);
        push  = ld_issue && !full;
        pop   = ld_resp_valid && !empty;
        acc   = alu_valid && !m_sk_v;
        wr = 1'b0; wa = '0; wd = '0;
        if (pop && !ld_resp_err) begin
            wr = 1'b1; wa = mq[0]; wd = ld_resp_data;
            if (acc) begin m_sk_v = 1'b1; m_sk_rd = alu_rd; m_sk_d = alu_wdata; end
        end else if (m_sk_v) begin
            wr = 1'b1; wa = m_sk_rd; wd = m_sk_d; m_sk_v = 1'b0;
        end else if (acc) begin
            wr = 1'b1; wa = alu_rd; wd = alu_wdata;
        end
        nerr = ld_resp_valid && (empty || ld_resp_err);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(ld_issue_rd);
        @(posedge clk);
        #1;
        m_wen = wr && (wa != 0);
        if (m_wen) begin m_waddr = wa; m_wdata = wd; end
        m_err = nerr;
        check_all(w);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic reset_mid(input string w);
        #2;
        rst = 1'b1;
        #1;
        chk({w, "_rst_wen"}, wen, 1'b0);
        chk({w, "_rst_alu_ready"}, alu_ready, 1'b1);
        chk({w, "_rst_ld_ready"}, ld_issue_ready, 1'b1);
        chk({w, "_rst_haz1"}, query_hazard1, 1'b0);
        chk({w, "_rst_haz2"}, query_hazard2, 1'b0);
        chk({w, "_rst_err"}, err_pulse, 1'b0);
        model_reset();
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all({w, "_rel"});
    endtask

    initial begin
        rst = 1'b1;
        query_addr1 = '0; query_addr2 = '0;
        idle();
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU-only write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'h11;
        cycle("alu");
        chk("alu_wen", wen, 1'b1);
        chk("alu_waddr", waddr, 5'd5);
        chk("alu_wdata", wdata, 32'h11);
        chk("alu_ready_stays", alu_ready, 1'b1);
        idle();
        cycle("alu_idle");

        // Load/ALU collision
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        cycle("col_issue");
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wdata = 32'h22;
        cycle("col_both");
        chk("col_w1_addr", waddr, 5'd3);
        chk("col_w1_data", wdata, 32'hAA);
        chk("col_alu_ready0", alu_ready, 1'b0);
        idle();
        cycle("col_drain");
        chk("col_w2_addr", waddr, 5'd7);
        chk("col_w2_data", wdata, 32'h22);
        chk("col_alu_ready1", alu_ready, 1'b1);
        cycle("col_idle");

        // Full FIFO and hazard tracking
        query_addr1 = 5'd2;
        ld_issue = 1'b1; ld_issue_rd = 5'd1;
        cycle("full_i1");
        ld_issue_rd = 5'd2;
        cycle("full_i2");
        chk("full_ready0", ld_issue_ready, 1'b0);
        chk("full_haz1", query_hazard1, 1'b1);
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h101;
        cycle("full_r1");
        chk("full_w1", waddr, 5'd1);
        ld_resp_data = 32'h202;
        cycle("full_r2");
        chk("full_w2", waddr, 5'd2);
        chk("full_ready1", ld_issue_ready, 1'b1);
        idle();
        cycle("full_idle");
        chk("full_haz1_clear", query_hazard1, 1'b0);

        // x0 destination and bus error
        query_addr1 = 5'd4;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        cycle("x0_i0");
        ld_issue_rd = 5'd4;
        cycle("x0_i4");
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h55;
        cycle("x0_r0");
        chk("x0_nowen0", wen, 1'b0);
        ld_resp_err = 1'b1; ld_resp_data = 32'h66;
        cycle("x0_rerr");
        chk("x0_nowen1", wen, 1'b0);
        chk("x0_err", err_pulse, 1'b1);
        idle();
        cycle("x0_idle");
        chk("x0_err_gone", err_pulse, 1'b0);
        chk("x0_empty", ld_issue_ready, 1'b1);
        chk("x0_haz_clear", query_hazard1, 1'b0);

        // Unexpected response
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        cycle("unexp");
        chk("unexp_err", err_pulse, 1'b1);
        chk("unexp_nowen", wen, 1'b0);
        idle();
        ld_issue = 1'b1; ld_issue_rd = 5'd6;
        cycle("unexp_cnt0");
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h88;
        cycle("unexp_cnt1");
        chk("unexp_pop_ok", waddr, 5'd6);
        idle();
        cycle("unexp_idle");

        // Reset mid-operation with a tag outstanding and the skid full
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        cycle("rm_i1");
        ld_issue_rd = 5'd10;
        cycle("rm_i2");
        idle();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_wdata = 32'h44;
        query_addr1 = 5'd10; query_addr2 = 5'd12;
        cycle("rm_fill");
        chk("rm_skid_full", alu_ready, 1'b0);
        chk("rm_haz1", query_hazard1, 1'b1);
        chk("rm_haz2", query_hazard2, 1'b1);
        idle();
        reset_mid("rm");
        ld_resp_valid = 1'b1; ld_resp_data = 32'h99;
        cycle("rm_post");
        chk("rm_post_err", err_pulse, 1'b1);
        chk("rm_post_nowen", wen, 1'b0);
        idle();
        cycle("rm_idle");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            alu_valid     = ($urandom_range(0, 1) == 1);
            alu_rd        = W_ADDR'($urandom_range(0, 7));
            alu_wdata     = $urandom;
            ld_issue      = ($urandom_range(0, 1) == 1);
            ld_issue_rd   = W_ADDR'($urandom_range(0, 7));
            ld_resp_valid = ($urandom_range(0, 2) == 0);
            ld_resp_data  = $urandom;
            ld_resp_err   = ($urandom_range(0, 7) == 0);
            query_addr1   = W_ADDR'($urandom_range(0, 7));
            query_addr2   = W_ADDR'($urandom_range(0, 31));
            if ($urandom_range(0, 199) == 0) begin
                idle();
                reset_mid("rnd");
            end else begin
                cycle("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
